// File: rtl/time_disp_pkg.sv
// Shared constants and types for the stopwatch time display scanner.
// Segment patterns are active-high, ordered {g,f,e,d,c,b,a}.
package time_disp_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [2:0] slot_t;
  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-high 7-segment pattern.
// Non-decimal nibbles (A-F) show a dash so corrupt bus data is visible.
module bcd_to_seg7
  import time_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/time_display_scan.sv
// 6-digit multiplexed 7-segment driver for the stopwatch time bus, frame-snapshotted.
// Define LEADING_ZERO_BLANK_EN to blank leading zero minute digits.
module time_display_scan
  import time_disp_pkg::*;
#(
  parameter int DIV_CNT    = 50000,
  parameter int BLINK_FRM  = 64,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk_core,
  input  logic       rst,
  input  logic [7:0] min_i,
  input  logic [7:0] sec_i,
  input  logic [7:0] ms_10_i,
  input  logic       blink_i,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic [5:0] an_o,
  output logic       frame_o
);

  localparam int DW = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
  localparam int BW = (BLINK_FRM > 1) ? $clog2(BLINK_FRM) : 1;

  logic          run;
  logic [DW-1:0] div;
  slot_t         slot;
  logic [BW-1:0] bcnt;
  logic          phase_on;
  logic          blink_q;
  logic [7:0]    snap_min, snap_sec, snap_ms;
  logic [6:0]    seg_q;
  logic [5:0]    an_q;
  logic          dp_q;
  logic          frame_q;

  logic          div_end, frame_end, frame_start;
  bcd_t          nib;
  logic [6:0]    seg_d;
  logic [5:0]    an_d;
  logic          dp_d;

  // run is low only for the first cycle after reset, which doubles as the first frame start
  assign div_end     = (div == DW'(DIV_CNT - 1));
  assign frame_end   = run && div_end && (slot == slot_t'(NUM_DIGITS - 1));
  assign frame_start = !run || frame_end;

  always_comb begin
    nib  = '0;
    an_d = '0;
    dp_d = 1'b0;
    case (slot)
      3'd0:    begin nib = snap_min[7:4]; an_d = 6'b100000; end
      3'd1:    begin nib = snap_min[3:0]; an_d = 6'b010000; dp_d = 1'b1; end
      3'd2:    begin nib = snap_sec[7:4]; an_d = 6'b001000; end
      3'd3:    begin nib = snap_sec[3:0]; an_d = 6'b000100; dp_d = 1'b1; end
      3'd4:    begin nib = snap_ms[7:4];  an_d = 6'b000010; end
      3'd5:    begin nib = snap_ms[3:0];  an_d = 6'b000001; end
      default: begin nib = '0;            an_d = '0; end
    endcase
    if (blink_q && !phase_on) an_d = '0;
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 3'd0 && snap_min[7:4] == 4'd0) an_d = '0;
    if (slot == 3'd1 && snap_min == 8'h00) begin
      an_d = '0;
      dp_d = 1'b0;
    end
`endif
  end

  bcd_to_seg7 u_dec (
    .bcd (nib),
    .seg (seg_d)
  );

  always_ff @(posedge clk_core) begin
    if (!rst) begin
      run      <= 1'b0;
      div      <= '0;
      slot     <= '0;
      bcnt     <= '0;
      phase_on <= 1'b1;
      blink_q  <= 1'b0;
      snap_min <= '0;
      snap_sec <= '0;
      snap_ms  <= '0;
      seg_q    <= SEG_OFF;
      an_q     <= '0;
      dp_q     <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      run     <= 1'b1;
      frame_q <= frame_start;
      if (frame_start) begin
        snap_min <= min_i;
        snap_sec <= sec_i;
        snap_ms  <= ms_10_i;
      end
      if (frame_start || div_end) blink_q <= blink_i;
      if (run) begin
        div <= div_end ? '0 : div + 1'b1;
        if (div_end) slot <= (slot == slot_t'(NUM_DIGITS - 1)) ? '0 : slot + 3'd1;
        // outputs trail the slot counter by one cycle so all three change together
        seg_q <= seg_d;
        an_q  <= an_d;
        dp_q  <= dp_d;
      end
      if (frame_end) begin
        if (bcnt == BW'(BLINK_FRM - 1)) begin
          bcnt     <= '0;
          phase_on <= ~phase_on;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
    end
  end

  assign seg_o   = seg_q ^ {7{ACTIVE_LOW}};
  assign an_o    = an_q ^ {6{ACTIVE_LOW}};
  assign dp_o    = dp_q ^ ACTIVE_LOW;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Randomized bench for time_display_scan against a time-indexed reference model.
// The model derives slot/frame/blink phase from the cycle count since reset release.
module tb_time_display_scan;

  localparam int D  = 4;
  localparam int BF = 2;

  logic       clk_core = 1'b0;
  logic       rst;
  logic [7:0] min_i, sec_i, ms_10_i;
  logic       blink_i;
  logic [6:0] seg_o;
  logic       dp_o;
  logic [5:0] an_o;
  logic       frame_o;

  int n_chk  = 0;
  int n_fail = 0;

  // model state
  int         t = -1;
  logic [7:0] s_min, s_sec, s_ms;
  logic       s_blk;
  logic [5:0] e_an  = 6'h3F;
  logic [6:0] e_seg = 7'h7F;
  logic       e_dp  = 1'b1;
  logic       e_frm = 1'b0;

  always #5 clk_core = ~clk_core;

  time_display_scan #(.DIV_CNT(D), .BLINK_FRM(BF), .ACTIVE_LOW(1'b1)) dut (
    .clk_core (clk_core),
    .rst      (rst),
    .min_i    (min_i),
    .sec_i    (sec_i),
    .ms_10_i  (ms_10_i),
    .blink_i  (blink_i),
    .seg_o    (seg_o),
    .dp_o     (dp_o),
    .an_o     (an_o),
    .frame_o  (frame_o)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Called right after each rising edge; t is the index of the cycle just ended.
  task automatic model_edge();
    int k, f;
    logic [23:0] dig;
    logic [3:0]  n;
    logic [5:0]  ah;
    logic        dh;
    if (!rst) begin
      t = -1; e_an = 6'h3F; e_seg = 7'h7F; e_dp = 1'b1; e_frm = 1'b0;
      return;
    end
    if (t >= 0) begin
      k   = (t % (6 * D)) / D;
      f   = t / (6 * D);
      dig = {s_min, s_sec, s_ms};
      n   = 4'(dig >> (20 - 4 * k));
      ah  = 6'(1 << (5 - k));
      dh  = (k == 1) || (k == 3);
      if (s_blk && ((f / BF) % 2 == 1)) ah = '0;
`ifdef LEADING_ZERO_BLANK_EN
      if (k == 0 && s_min[7:4] == 4'd0) ah = '0;
      if (k == 1 && s_min == 8'h00) begin ah = '0; dh = 1'b0; end
`endif
      e_an  = ~ah;
      e_seg = ~seg_of(n);
      e_dp  = ~dh;
    end
    t++;
    e_frm = (t % (6 * D) == 0);
    if (e_frm) {s_min, s_sec, s_ms} = {min_i, sec_i, ms_10_i};
    if (t % D == 0) s_blk = blink_i;
  endtask

  task automatic step();
    @(posedge clk_core);
    model_edge();
    @(negedge clk_core);
    chk("an",    8'(an_o),    8'(e_an));
    chk("seg",   8'(seg_o),   8'(e_seg));
    chk("dp",    8'(dp_o),    8'(e_dp));
    chk("frame", 8'(frame_o), 8'(e_frm));
  endtask

  function automatic logic [7:0] rnd_bcd(input int tens_max);
    return {4'($urandom_range(0, tens_max)), 4'($urandom_range(0, 9))};
  endfunction

  initial begin
    rst = 1'b0; min_i = '0; sec_i = '0; ms_10_i = '0; blink_i = 1'b0;
    repeat (3) step();
    // first cycle after release must pulse frame
    rst = 1'b1;
    min_i = 8'h12; sec_i = 8'h34; ms_10_i = 8'h56;
    repeat (48) step();
    // change seconds mid-frame (slot 2); takes effect next frame only
    while (t % (6 * D) != 2 * D + 1) step();
    sec_i = 8'h35;
    repeat (40) step();
    ms_10_i = 8'hA9;
    repeat (30) step();
    blink_i = 1'b1;
    repeat (6 * D * 5) step();
    blink_i = 1'b0;
    repeat (6 * D * 2) step();
    min_i = 8'h00; sec_i = 8'h07; ms_10_i = 8'h00;
    repeat (6 * D * 2) step();
    // mid-frame reset
    rst = 1'b0;
    step();
    rst = 1'b1;
    repeat (30) step();
    for (int i = 0; i < 600; i++) begin
      min_i   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : rnd_bcd(5);
      sec_i   = rnd_bcd(5);
      ms_10_i = ($urandom_range(0, 7) == 0) ? 8'($urandom) : rnd_bcd(9);
      if ($urandom_range(0, 19) == 0) blink_i = ~blink_i;
      rst = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
